// File: rtl/up_down_counter_sequencer.sv
// Prescaled up/down counter sequencer with SINGLE, REPEAT and BOUNCE run modes.
// The run configuration is latched when a run starts. All outputs come straight from registers.
module up_down_counter_sequencer #(
  parameter int WIDTH = 4,
  parameter int DIV_W = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic             up_down,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIDTH-1:0] end_val,
  input  logic [DIV_W-1:0] div,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic             dir,
  output logic             wrap
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] M_REPEAT = 2'b01;
  localparam logic [1:0] M_BOUNCE = 2'b10;

  state_t           state_q;
  logic [1:0]       mode_q;
  logic             updn_q;
  logic [WIDTH-1:0] sv_q;
  logic [WIDTH-1:0] ev_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] presc_q;
  logic [WIDTH-1:0] q_q;
  logic             dir_q;
  logic             busy_q;
  logic             done_q;
  logic             wrap_q;

  logic             tick;
  logic             at_end;
  logic             at_start;
  logic             same_ends;
  logic             bounce_dir_d;
  logic             step_dir_d;
  logic [WIDTH-1:0] step_val_d;
  logic             step_wrap_d;

  assign tick      = (presc_q == div_q);
  assign at_end    = (q_q == ev_q);
  assign at_start  = (q_q == sv_q);
  assign same_ends = (sv_q == ev_q);

  // BOUNCE turns around only at the end value while moving in the initial
  // direction, and turns back only at the start value while moving against it.
  always_comb begin
    bounce_dir_d = dir_q;
    if (at_end && (dir_q == updn_q))
      bounce_dir_d = ~dir_q;
    else if (at_start && (dir_q != updn_q))
      bounce_dir_d = updn_q;
  end

  always_comb begin
    step_dir_d  = (mode_q == M_BOUNCE) ? bounce_dir_d : dir_q;
    step_val_d  = step_dir_d ? (q_q + 1'b1) : (q_q - 1'b1);
    step_wrap_d = step_dir_d ? (&q_q) : (q_q == '0);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      updn_q  <= 1'b0;
      sv_q    <= '0;
      ev_q    <= '0;
      div_q   <= '0;
      presc_q <= '0;
      q_q     <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            mode_q  <= mode;
            updn_q  <= up_down;
            sv_q    <= start_val;
            ev_q    <= end_val;
            div_q   <= div;
            presc_q <= '0;
            q_q     <= start_val;
            dir_q   <= up_down;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            // abort wins over any terminal tick in the same cycle
            presc_q <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (!tick) begin
            presc_q <= presc_q + 1'b1;
          end else begin
            presc_q <= '0;
            case (mode_q)
              M_REPEAT: begin
                if (at_end) begin
                  q_q    <= sv_q;
                  wrap_q <= 1'b1;
                end else begin
                  q_q    <= step_val_d;
                  wrap_q <= step_wrap_d;
                end
              end
              M_BOUNCE: begin
                if (!same_ends) begin
                  q_q    <= step_val_d;
                  dir_q  <= step_dir_d;
                  wrap_q <= step_wrap_d;
                end
              end
              default: begin
                if (at_end) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
                end else begin
                  q_q    <= step_val_d;
                  wrap_q <= step_wrap_d;
                end
              end
            endcase
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Q    = q_q;
  assign busy = busy_q;
  assign done = done_q;
  assign dir  = dir_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_up_down_counter_sequencer.sv
// Self-checking bench: directed scenarios plus randomized runs against a
// behavioural model of the run sequencer.
module tb_up_down_counter_sequencer;
  localparam int W   = 4;
  localparam int DW  = 4;
  localparam int TOP = 1 << W;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          up_down = 1'b1;
  logic [W-1:0]  start_val = '0;
  logic [W-1:0]  end_val = '0;
  logic [DW-1:0] div = '0;
  logic [W-1:0]  Q;
  logic          busy, done, dir, wrap;

  int errors = 0;
  int checks = 0;

  up_down_counter_sequencer #(.WIDTH(W), .DIV_W(DW)) dut (
    .Clock(Clock), .Reset(Reset), .start(start), .abort(abort), .mode(mode),
    .up_down(up_down), .start_val(start_val), .end_val(end_val), .div(div),
    .Q(Q), .busy(busy), .done(done), .dir(dir), .wrap(wrap)
  );

  always #5 Clock = ~Clock;

  // Behavioural model: 0 idle, 1 running, 2 finished (done cycle)
  int m_st, m_q, m_left;
  bit m_dir, m_busy, m_done, m_wrap;
  int c_mode, c_start, c_end, c_div;
  bit c_ud;

  function automatic void mdl_reset();
    m_st = 0; m_q = 0; m_left = 0;
    m_dir = 0; m_busy = 0; m_done = 0; m_wrap = 0;
    c_mode = 0; c_start = 0; c_end = 0; c_div = 0; c_ud = 0;
  endfunction

  function automatic void mstep(bit up);
    int nq;
    nq = up ? m_q + 1 : m_q - 1;
    if (nq >= TOP) begin nq = 0; m_wrap = 1; end
    else if (nq < 0) begin nq = TOP - 1; m_wrap = 1; end
    m_q = nq;
  endfunction

  function automatic void mdl_edge();
    if (!Reset) begin mdl_reset(); return; end
    m_wrap = 0;
    m_done = 0;
    if (m_st == 0) begin
      if (start && !abort) begin
        c_mode = mode; c_ud = up_down; c_start = start_val; c_end = end_val; c_div = div;
        m_q = c_start; m_dir = c_ud; m_busy = 1; m_st = 1; m_left = c_div;
      end
    end else if (m_st == 1) begin
      if (abort) begin
        m_st = 0; m_busy = 0;
      end else if (m_left > 0) begin
        m_left--;
      end else begin
        m_left = c_div;
        if (c_mode == 1) begin
          if (m_q == c_end) begin m_q = c_start; m_wrap = 1; end
          else mstep(m_dir);
        end else if (c_mode == 2) begin
          if (c_start != c_end) begin
            if (m_q == c_end && m_dir == c_ud) m_dir = !m_dir;
            else if (m_q == c_start && m_dir != c_ud) m_dir = c_ud;
            mstep(m_dir);
          end
        end else begin
          if (m_q == c_end) begin m_st = 2; m_busy = 0; m_done = 1; end
          else mstep(m_dir);
        end
      end
    end else begin
      m_st = 0;
    end
  endfunction

  function automatic logic [W+3:0] exp_vec();
    logic [W-1:0] qv;
    qv = m_q[W-1:0];
    return {qv, m_dir, m_busy, m_done, m_wrap};
  endfunction

  task automatic clk_step();
    @(posedge Clock);
    mdl_edge();
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] md, input logic ud, input int sv, input int ev, input int dv);
    mode = md; up_down = ud;
    start_val = W'(sv); end_val = W'(ev); div = DW'(dv);
  endtask

  task automatic test_reset();
    #2 Reset = 1'b0;
    #1;
    mdl_reset();
    checks++;
    if ({Q, dir, busy, done, wrap} !== '0) begin
      errors++;
      $display("FAIL reset_async got=%h want=0", {Q, dir, busy, done, wrap});
    end
    start = 1'b1;
    set_cfg(2'b00, 1'b1, 5, 9, 0);
    clk_step();
    checks++;
    if ({Q, dir, busy, done, wrap} !== exp_vec()) begin
      errors++;
      $display("FAIL reset_hold got=%h want=%h", {Q, dir, busy, done, wrap}, exp_vec());
    end
    start = 1'b0;
    Reset = 1'b1;
    clk_step();
    checks++;
    if ({Q, dir, busy, done, wrap} !== exp_vec()) begin
      errors++;
      $display("FAIL reset_release got=%h want=%h", {Q, dir, busy, done, wrap}, exp_vec());
    end
  endtask

  task automatic test_single_up();
    int dones = 0;
    logic [W-1:0] seq[$];
    set_cfg(2'b00, 1'b1, 3, 7, 0);
    start = 1'b1;
    clk_step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (busy) seq.push_back(Q);
      if (done) begin
        dones++;
        checks++;
        if (busy !== 1'b0 || Q !== 4'd7) begin
          errors++;
          $display("FAIL single_up_done busy=%b Q=%h want busy=0 Q=7", busy, Q);
        end
      end
      checks++;
      if ({Q, dir, busy, done, wrap} !== exp_vec()) begin
        errors++;
        $display("FAIL single_up cyc=%0d got=%h want=%h", i, {Q, dir, busy, done, wrap}, exp_vec());
      end
      clk_step();
    end
    checks++;
    if (dones != 1 || seq.size() != 5 || seq[0] !== 4'd3 || seq[4] !== 4'd7) begin
      errors++;
      $display("FAIL single_up_seq dones=%0d len=%0d want dones=1 len=5 3..7", dones, seq.size());
    end
  endtask

  task automatic test_single_down_wrap();
    int dones = 0, wraps = 0;
    set_cfg(2'b00, 1'b0, 1, 14, 0);
    start = 1'b1;
    clk_step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (done) dones++;
      if (wrap) begin
        wraps++;
        checks++;
        if (Q !== 4'hF) begin
          errors++;
          $display("FAIL down_wrap_val Q=%h want=f", Q);
        end
      end
      checks++;
      if ({Q, dir, busy, done, wrap} !== exp_vec()) begin
        errors++;
        $display("FAIL single_down cyc=%0d got=%h want=%h", i, {Q, dir, busy, done, wrap}, exp_vec());
      end
      clk_step();
    end
    checks++;
    if (dones != 1 || wraps != 1) begin
      errors++;
      $display("FAIL single_down_counts dones=%0d wraps=%0d want 1 and 1", dones, wraps);
    end
  endtask

  task automatic test_repeat_prescale();
    int wraps = 0;
    set_cfg(2'b01, 1'b1, 2, 4, 2);
    start = 1'b1;
    clk_step();
    start = 1'b0;
    // 9 cycles per lap (3 values x 3 cycles): 27 cycles cover 3 reloads
    for (int i = 0; i < 28; i++) begin
      if (wrap) wraps++;
      checks++;
      if ({Q, dir, busy, done, wrap} !== exp_vec()) begin
        errors++;
        $display("FAIL repeat cyc=%0d got=%h want=%h", i, {Q, dir, busy, done, wrap}, exp_vec());
      end
      clk_step();
    end
    checks++;
    if (wraps != 3) begin
      errors++;
      $display("FAIL repeat_wraps got=%0d want=3", wraps);
    end
    abort = 1'b1;
    clk_step();
    abort = 1'b0;
  endtask

  task automatic test_bounce();
    set_cfg(2'b10, 1'b1, 5, 8, 0);
    start = 1'b1;
    clk_step();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({Q, dir, busy, done, wrap} !== exp_vec()) begin
        errors++;
        $display("FAIL bounce cyc=%0d got=%h want=%h", i, {Q, dir, busy, done, wrap}, exp_vec());
      end
      if (i == 4) begin
        checks++;
        if (Q !== 4'd7 || dir !== 1'b0) begin
          errors++;
          $display("FAIL bounce_turn Q=%h dir=%b want Q=7 dir=0", Q, dir);
        end
      end
      clk_step();
    end
    abort = 1'b1;
    clk_step();
    abort = 1'b0;
  endtask

  task automatic test_abort_reset();
    set_cfg(2'b00, 1'b1, 3, 4, 0);
    start = 1'b1;
    clk_step();
    start = 1'b0;
    clk_step();
    abort = 1'b1;
    clk_step();
    abort = 1'b0;
    checks++;
    if ({Q, busy, done} !== {4'd4, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort_terminal Q=%h busy=%b done=%b want Q=4 busy=0 done=0", Q, busy, done);
    end
    clk_step();
    checks++;
    if ({Q, dir, busy, done, wrap} !== exp_vec()) begin
      errors++;
      $display("FAIL abort_after got=%h want=%h", {Q, dir, busy, done, wrap}, exp_vec());
    end
    set_cfg(2'b01, 1'b0, 9, 2, 1);
    start = 1'b1;
    clk_step();
    start = 1'b0;
    repeat (4) clk_step();
    #2 Reset = 1'b0;
    #1;
    mdl_reset();
    checks++;
    if ({Q, dir, busy, done, wrap} !== '0) begin
      errors++;
      $display("FAIL reset_midrun got=%h want=0", {Q, dir, busy, done, wrap});
    end
    clk_step();
    Reset = 1'b1;
    set_cfg(2'b00, 1'b1, 10, 12, 0);
    start = 1'b1;
    clk_step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({Q, dir, busy, done, wrap} !== exp_vec()) begin
        errors++;
        $display("FAIL post_reset_run cyc=%0d got=%h want=%h", i, {Q, dir, busy, done, wrap}, exp_vec());
      end
      clk_step();
    end
  endtask

  task automatic test_start_ignored_equal();
    int done_at = -1;
    set_cfg(2'b00, 1'b1, 6, 6, 3);
    start = 1'b1;
    clk_step();
    for (int i = 0; i < 6; i++) begin
      start_val = W'($urandom);
      end_val = W'($urandom);
      div = DW'($urandom);
      if (done && done_at < 0) done_at = i;
      checks++;
      if ({Q, dir, busy, done, wrap} !== exp_vec()) begin
        errors++;
        $display("FAIL start_ignored cyc=%0d got=%h want=%h", i, {Q, dir, busy, done, wrap}, exp_vec());
      end
      clk_step();
    end
    start = 1'b0;
    checks++;
    if (done_at != 4) begin
      errors++;
      $display("FAIL equal_done_time got=%0d want=4", done_at);
    end
    abort = 1'b1;
    repeat (2) clk_step();
    abort = 1'b0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      set_cfg(2'($urandom), 1'($urandom), int'($urandom_range(0, TOP - 1)),
              int'($urandom_range(0, TOP - 1)), int'($urandom_range(0, 3)));
      start = 1'b1;
      clk_step();
      for (int i = 0; i < 60; i++) begin
        start = ($urandom_range(0, 9) == 0);
        abort = ($urandom_range(0, 49) == 0);
        if ($urandom_range(0, 7) == 0)
          set_cfg(2'($urandom), 1'($urandom), int'($urandom_range(0, TOP - 1)),
                  int'($urandom_range(0, TOP - 1)), int'($urandom_range(0, 3)));
        checks++;
        if ({Q, dir, busy, done, wrap} !== exp_vec()) begin
          errors++;
          $display("FAIL random run=%0d cyc=%0d got=%h want=%h", r, i, {Q, dir, busy, done, wrap}, exp_vec());
        end
        clk_step();
      end
      start = 1'b0;
      abort = 1'b1;
      clk_step();
      abort = 1'b0;
    end
  endtask

  initial begin
    mdl_reset();
    test_reset();
    test_single_up();
    test_single_down_wrap();
    test_repeat_prescale();
    test_bounce();
    test_abort_reset();
    test_start_ignored_equal();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/up_down_counter_sequencer.md
UP_DOWN_COUNTER_SEQUENCER -- requirements
Module: up_down_counter_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, count width.
REQ-002 SHALL have parameter DIV_W, default 4, prescaler divide-field width.
REQ-003 SHALL have port Clock  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  run request, sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  stop run, return to IDLE.
REQ-007 SHALL have port mode  input  2  00 SINGLE, 01 REPEAT, 10 BOUNCE, 11 treated as SINGLE.
REQ-008 SHALL have port up_down  input  1  initial direction: 1 up, 0 down.
REQ-009 SHALL have port start_val  input  WIDTH  first count value.
REQ-010 SHALL have port end_val  input  WIDTH  terminal count value.
REQ-011 SHALL have port div  input  DIV_W  step every div+1 cycles.
REQ-012 SHALL have port Q  output  WIDTH  current count.
REQ-013 SHALL have port busy  output  1  high in RUN.
REQ-014 SHALL have port done  output  1  one-cycle pulse on SINGLE completion.
REQ-015 SHALL have port dir  output  1  current direction, 1 up.
REQ-016 SHALL have port wrap  output  1  one-cycle pulse on F->0 / 0->F roll or REPEAT reload.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE; busy=1 only in RUN.
REQ-018 SHALL, in IDLE with start=1 and abort=0 at edge N, latch mode, up_down, start_val, end_val, div; Q=start_val, dir=up_down, busy=1, state RUN at N+1.
REQ-019 SHALL ignore start while in RUN or DONE; latched config unaffected by input changes during RUN.
REQ-020 SHALL clear prescaler to 0 on entry to RUN; in RUN, tick when prescaler==div, then prescaler wraps to 0, else increments.
REQ-021 SHALL make first tick div+1 cycles after RUN entry (div=0: Q changes at N+2).
REQ-022 SHALL, on tick with Q!=end_val, step Q by +1 (dir=1) or -1 (dir=0), modulo 2^WIDTH; wrap pulses on all-ones->0 or 0->all-ones.
REQ-023 SHALL, SINGLE, on tick with Q==end_val: hold Q, enter DONE; DONE lasts one cycle with done=1, busy=0, then IDLE.
REQ-024 SHALL, REPEAT, on tick with Q==end_val: Q<=start_val, wrap=1 that cycle, stay RUN.
REQ-025 SHALL, BOUNCE, on tick: if Q==end_val and dir==latched up_down, invert dir and step in new direction; if Q==start_val and dir!=latched up_down, restore dir and step; else step normally.
REQ-026 SHALL, BOUNCE with start_val==end_val, hold Q and dir constant on ticks.
REQ-027 SHALL, SINGLE with start_val==end_val, enter DONE on first tick without stepping.
REQ-028 SHALL, abort=1 in RUN, enter IDLE next edge, hold Q, no done pulse, prescaler cleared.
REQ-029 SHALL give abort priority over start and over a coincident terminal tick (no done).
REQ-030 SHALL hold Q and dir in IDLE and DONE; wrap and done are 0 outside their pulse cycles.

Reset
REQ-031 SHALL, on Reset=0, immediately force state IDLE, Q=0, busy=0, done=0, dir=0, wrap=0, prescaler=0, latched config=0, regardless of Clock.
REQ-032 SHALL abandon any run on Reset mid-operation; first start after Reset release behaves per REQ-018.

Verification
REQ-033 SHALL cover SINGLE up: start_val=3, end_val=7, div=0 -> Q 3,4,5,6,7; done pulse one cycle after Q=7 tick; busy low with done.
REQ-034 SHALL cover SINGLE down wrap: start_val=1, end_val=E, up_down=0, div=0 -> Q 1,0,F,E; wrap at 0->F; done once.
REQ-035 SHALL cover REPEAT with prescale: start_val=2, end_val=4, div=2 -> each value held 3 cycles, sequence 2,3,4,2,...; wrap pulse on each reload.
REQ-036 SHALL cover BOUNCE: start_val=5, end_val=8, up_down=1, div=0 -> Q 5,6,7,8,7,6,5,6...; dir toggles at 8 and 5.
REQ-037 SHALL cover abort/reset: abort coincident with Q==end_val tick in SINGLE -> IDLE, no done; Reset low mid-RUN -> all outputs 0 asynchronously.
REQ-038 SHALL cover start during RUN ignored and start_val==end_val SINGLE -> done after div+1 cycles, Q unchanged.
